// File: rtl/mac_rr_scheduler.sv
// Round-robin arbitrated front end for one shared 3-stage unsigned a*b+c pipeline.
// Each result returns tagged with the ID of the requester that issued it.
module mac_rr_scheduler #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   a_bus,
    input  logic [N*W-1:0]   b_bus,
    input  logic [N*W-1:0]   c_bus,
    output logic [N-1:0]     gnt,
    output logic             rsp_valid,
    output logic [IDW-1:0]   rsp_id,
    output logic [2*W-1:0]   rsp_data,
    output logic [1:0]       inflight
);

    localparam int unsigned NU = N;

    logic [W-1:0]     a_arr [N];
    logic [W-1:0]     b_arr [N];
    logic [W-1:0]     c_arr [N];

    logic [IDW-1:0]   last_q, last_d;
    logic [IDW-1:0]   pick_idx;
    logic [IDW-1:0]   cand_idx;
    int unsigned      cand;
    logic             pick_found;
    logic             accept;

    logic             v1_q, v1_d;
    logic [W-1:0]     a1_q, a1_d;
    logic [W-1:0]     b1_q, b1_d;
    logic [W-1:0]     c1_q, c1_d;
    logic [IDW-1:0]   id1_q, id1_d;

    logic             v2_q, v2_d;
    logic [2*W-1:0]   p2_q, p2_d;
    logic [W-1:0]     c2_q, c2_d;
    logic [IDW-1:0]   id2_q, id2_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [2*W-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]       inflight_q, inflight_d;

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign a_arr[gi] = a_bus[gi*W +: W];
        assign b_arr[gi] = b_bus[gi*W +: W];
        assign c_arr[gi] = c_bus[gi*W +: W];
    end

    // Scan last+1, last+2, ... modulo N; the first active request wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        cand_idx   = '0;
        for (int unsigned off = 1; off <= NU; off++) begin
            cand     = (32'(last_q) + off) % NU;
            cand_idx = cand[IDW-1:0];
            if (!pick_found && req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        gnt    = '0;
        accept = pick_found & en & ~rst;
        if (accept) begin
            gnt[pick_idx] = 1'b1;
        end
        last_d = accept ? pick_idx : last_q;
    end

    // Only the granted requester's slice is ever captured, so idle slices cannot leak X.
    always_comb begin
        v1_d  = accept;
        a1_d  = a1_q;
        b1_d  = b1_q;
        c1_d  = c1_q;
        id1_d = id1_q;
        if (accept) begin
            a1_d  = a_arr[pick_idx];
            b1_d  = b_arr[pick_idx];
            c1_d  = c_arr[pick_idx];
            id1_d = pick_idx;
        end
    end

    always_comb begin
        v2_d  = v1_q;
        p2_d  = p2_q;
        c2_d  = c2_q;
        id2_d = id2_q;
        if (v1_q) begin
            p2_d  = (2*W)'(a1_q) * (2*W)'(b1_q);
            c2_d  = c1_q;
            id2_d = id1_q;
        end
    end

    always_comb begin
        rsp_valid_d = v2_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (v2_q) begin
            rsp_id_d   = id2_q;
            rsp_data_d = p2_q + (2*W)'(c2_q);
        end
    end

    // A result sitting in stage 3 always leaves on the next edge.
    always_comb begin
        inflight_d = inflight_q;
        case ({accept, rsp_valid_q})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= IDW'(N - 1);
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            inflight_q  <= '0;
        end else begin
            last_q      <= last_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            inflight_q  <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        a1_q  <= a1_d;
        b1_q  <= b1_d;
        c1_q  <= c1_d;
        id1_q <= id1_d;
        p2_q  <= p2_d;
        c2_q  <= c2_d;
        id2_q <= id2_d;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign inflight  = inflight_q;

endmodule
